// File: rtl/n_slot_alloc_pkg.sv
// Shared definitions for the next-fit slot allocator: default size,
// index-width helper and the occupancy-counter update encoding.
package n_slot_alloc_pkg;

    localparam int DEFAULT_W = 32;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // Never returns 0, so a 2-slot pool still gets a 1-bit index.
    function automatic int idx_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
        if (inc && !dec) return CNT_INC;
        if (dec && !inc) return CNT_DEC;
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/n_slot_alloc_if.sv
// Allocator request/response bus. Handshake: a grant happens in a cycle where
// alloc_vld_i and alloc_rdy_o are both 1; rsp_vld_o/rsp_idx_o report it one cycle later.
interface n_slot_alloc_if
    import n_slot_alloc_pkg::*;
#(
    parameter int W = DEFAULT_W
);
    localparam int IDX_W = idx_width(W);

    logic             alloc_vld_i;
    logic             alloc_rdy_o;
    logic             rsp_vld_o;
    logic [IDX_W-1:0] rsp_idx_o;
    logic             free_vld_i;
    logic [IDX_W-1:0] free_idx_i;
    logic [W-1:0]     occ_o;
    logic [IDX_W:0]   count_o;
    logic             full_o;
    logic             empty_o;
    logic             err_o;

    modport slave (
        input  alloc_vld_i, free_vld_i, free_idx_i,
        output alloc_rdy_o, rsp_vld_o, rsp_idx_o, occ_o, count_o, full_o, empty_o, err_o
    );

    modport master (
        output alloc_vld_i, free_vld_i, free_idx_i,
        input  alloc_rdy_o, rsp_vld_o, rsp_idx_o, occ_o, count_o, full_o, empty_o, err_o
    );

endinterface

// File: rtl/n_slot_alloc_ffz_rot.sv
// First free slot at or after a run-time pointer, wrapping at W.
// Rotates the bitmap so ptr sits at bit 0, isolates the lowest zero, rotates back.
module n_slot_alloc_ffz_rot
    import n_slot_alloc_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int IDX_W = idx_width(W)
) (
    input  logic [W-1:0]     occ_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [2*W-1:0] rot_dbl;
    logic [W-1:0]   rot;
    logic [W-1:0]   rot_oh;
    logic [2*W-1:0] back_dbl;
    logic [W-1:0]   one_hot;

    // Doubling the vector makes the shift a true W-bit rotation for any W.
    assign rot_dbl  = {occ_i, occ_i} >> ptr_i;
    assign rot      = rot_dbl[W-1:0];
    assign rot_oh   = (rot + W'(1)) & ~rot;
    assign back_dbl = {rot_oh, rot_oh} << ptr_i;
    assign one_hot  = back_dbl[2*W-1:W];
    assign found_o  = |one_hot;

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < W; i++) begin
            if (one_hot[i]) idx_o = idx_o | IDX_W'(i);
        end
    end

endmodule

// File: rtl/n_slot_alloc.sv
// Next-fit slot allocator: occupancy bitmap, rotating search pointer,
// registered grant response, occupancy count and illegal-free error pulse.
module n_slot_alloc
    import n_slot_alloc_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    n_slot_alloc_if.slave bus
);

    localparam int IDX_W = idx_width(W);
    localparam int CNT_W = IDX_W + 1;
    localparam int EXT_W = 1 << IDX_W;

    logic [W-1:0]     occ_q,     occ_d;
    logic [IDX_W-1:0] ptr_q,     ptr_d;
    logic             rsp_vld_q;
    logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             full_q;
    logic             empty_q;
    logic             err_q;

    logic             found;
    logic [IDX_W-1:0] grant_idx;
    logic             alloc_rdy;
    logic             fire;
    logic [EXT_W-1:0] occ_ext;
    logic             free_legal;
    logic             free_err;
    logic [W-1:0]     free_oh;
    logic [W-1:0]     grant_oh;

    n_slot_alloc_ffz_rot #(
        .W     (W),
        .IDX_W (IDX_W)
    ) u_ffz (
        .occ_i   (occ_q),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (grant_idx)
    );

    // Padding slots past W read as free, so out-of-range frees land as illegal.
    always_comb begin
        occ_ext          = '0;
        occ_ext[W-1:0]   = occ_q;
    end

    assign alloc_rdy  = rst_n & ~full_q;
    assign fire       = bus.alloc_vld_i & alloc_rdy & found;
    assign free_legal = bus.free_vld_i & occ_ext[bus.free_idx_i];
    assign free_err   = bus.free_vld_i & ~occ_ext[bus.free_idx_i];
    assign free_oh    = {{(W-1){1'b0}}, free_legal} << bus.free_idx_i;
    assign grant_oh   = {{(W-1){1'b0}}, fire} << grant_idx;

    always_comb begin
        occ_d     = (occ_q & ~free_oh) | grant_oh;
        ptr_d     = ptr_q;
        rsp_idx_d = rsp_idx_q;
        if (fire) begin
            ptr_d     = (grant_idx == IDX_W'(W - 1)) ? '0 : grant_idx + IDX_W'(1);
            rsp_idx_d = grant_idx;
        end
        unique case (cnt_op(fire, free_legal))
            CNT_INC: count_d = count_q + CNT_W'(1);
            CNT_DEC: count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q     <= '0;
            ptr_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_idx_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            occ_q     <= occ_d;
            ptr_q     <= ptr_d;
            rsp_vld_q <= fire;
            rsp_idx_q <= rsp_idx_d;
            count_q   <= count_d;
            full_q    <= (count_d == CNT_W'(W));
            empty_q   <= (count_d == '0);
            err_q     <= free_err;
        end
    end

    assign bus.alloc_rdy_o = alloc_rdy;
    assign bus.rsp_vld_o   = rsp_vld_q;
    assign bus.rsp_idx_o   = rsp_idx_q;
    assign bus.occ_o       = occ_q;
    assign bus.count_o     = count_q;
    assign bus.full_o      = full_q;
    assign bus.empty_o     = empty_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_n_slot_alloc.sv
// Bench for n_slot_alloc at W=8: directed vector table, then a randomised
// alloc/free run checked against a simple next-fit reference model.
module tb_n_slot_alloc;
    import n_slot_alloc_pkg::*;

    localparam int W     = 8;
    localparam int IDX_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    n_slot_alloc_if #(.W(W)) bus();

    n_slot_alloc #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic             rst;
        logic             av;
        logic             fv;
        logic [IDX_W-1:0] fi;
        logic             rv;
        logic [IDX_W-1:0] ri;
        logic [W-1:0]     occ;
        int               cnt;
        logic             err;
    } vec_t;

    vec_t             tbl[$];
    logic [IDX_W-1:0] exp_q[$];
    int               n_cmp  = 0;
    int               n_fail = 0;

    function automatic vec_t mk(input logic rst, input logic av, input logic fv, input int fi,
                                input logic rv, input int ri, input logic [W-1:0] occ,
                                input int cnt, input logic err);
        vec_t v;
        v.rst = rst;  v.av = av;  v.fv = fv;  v.fi = IDX_W'(fi);
        v.rv  = rv;   v.ri = IDX_W'(ri);
        v.occ = occ;  v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t v);
        logic [IDX_W-1:0] e;
        rst_n           = v.rst;
        bus.alloc_vld_i = v.av;
        bus.free_vld_i  = v.fv;
        bus.free_idx_i  = v.fi;
        if (!v.rst) exp_q.delete();
        else if (v.rv) exp_q.push_back(v.ri);
        @(posedge clk);
        #1;
        chk("rsp_vld", int'(bus.rsp_vld_o), int'(v.rv));
        if (bus.rsp_vld_o || v.rv) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rsp_idx: got grant %0d expected none (t=%0t)", bus.rsp_idx_o, $time);
            end else begin
                e = exp_q.pop_front();
                if (bus.rsp_vld_o) chk("rsp_idx", int'(bus.rsp_idx_o), int'(e));
            end
        end
        if (!v.rst) chk("rst_rsp_idx", int'(bus.rsp_idx_o), 0);
        chk("occ",   int'(bus.occ_o),       int'(v.occ));
        chk("count", int'(bus.count_o),     v.cnt);
        chk("full",  int'(bus.full_o),      int'(v.cnt == W));
        chk("empty", int'(bus.empty_o),     int'(v.cnt == 0));
        chk("err",   int'(bus.err_o),       int'(v.err));
        chk("rdy",   int'(bus.alloc_rdy_o), int'(v.rst && (v.cnt != W)));
    endtask

    logic [W-1:0]     m_occ;
    int               m_ptr;
    int               m_cnt;

    initial begin
        bus.alloc_vld_i = 1'b0;
        bus.free_vld_i  = 1'b0;
        bus.free_idx_i  = '0;

        // Reset, then fill all eight slots; the ninth request is refused.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
        for (int k = 0; k < W; k++)
            tbl.push_back(mk(1, 1, 0, 0, 1, k, W'((1 << (k + 1)) - 1), k + 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8'hFF, 8, 0));
        // From full with ptr=0: free 3 then grant 3; frees of 5 and 2 show ptr=4.
        tbl.push_back(mk(1, 0, 1, 3, 0, 0, 8'hF7, 7, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 3, 8'hFF, 8, 0));
        tbl.push_back(mk(1, 0, 1, 5, 0, 0, 8'hDF, 7, 0));
        tbl.push_back(mk(1, 0, 1, 2, 0, 0, 8'hDB, 6, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 5, 8'hFB, 7, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 2, 8'hFF, 8, 0));
        // Full: request ignored while a legal free reopens slot 0.
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 8'hFE, 7, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 8'hFF, 8, 0));
        // Reset, free while empty, error clears next cycle.
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0));
        // Next-fit: occ=0000_0111, ptr=3, free 1, grants 3 then 4.
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 8'h01, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 8'h03, 2, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 2, 8'h07, 3, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 8'h05, 2, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 3, 8'h0D, 3, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 4, 8'h1D, 4, 0));
        // Illegal free of unoccupied 5: one-cycle error, state unchanged.
        tbl.push_back(mk(1, 0, 1, 5, 0, 0, 8'h1D, 4, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h1D, 4, 0));
        // Same-cycle alloc and legal free of 0 at count 4.
        tbl.push_back(mk(1, 1, 1, 0, 1, 5, 8'h3C, 4, 0));
        // Illegal free of the slot being granted: grant wins, error pulses.
        tbl.push_back(mk(1, 1, 1, 6, 1, 6, 8'h7C, 5, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1, 7, 8'hFC, 6, 0));
        // Reset while rsp_vld=1 and count=6; next grant is slot 0.
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 8'h01, 1, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Randomised run against the reference model, starting from reset.
        step(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
        m_occ = '0;
        m_ptr = 0;
        m_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            logic av, fv, rst, fire, legal, found;
            int   fi, g;
            rst   = ($urandom_range(0, 99) != 0);
            av    = ($urandom_range(0, 9) < 6);
            fv    = ($urandom_range(0, 9) < 5);
            fi    = $urandom_range(0, W - 1);
            fire  = rst && av && (m_cnt != W);
            legal = rst && fv && m_occ[fi];
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < W; k++) begin
                int j;
                j = (m_ptr + k) % W;
                if (!found && !m_occ[j]) begin
                    found = 1'b1;
                    g     = j;
                end
            end
            if (!rst) begin
                m_occ = '0;
                m_ptr = 0;
                m_cnt = 0;
                v = mk(0, av, fv, fi, 0, 0, 8'h00, 0, 0);
            end else begin
                if (legal) m_occ[fi] = 1'b0;
                if (fire) begin
                    m_occ[g] = 1'b1;
                    m_ptr    = (g == W - 1) ? 0 : g + 1;
                end
                m_cnt = m_cnt + int'(fire) - int'(legal);
                v = mk(1, av, fv, fi, fire, g, m_occ, m_cnt, fv && !legal);
            end
            step(v);
        end

        chk("leftover_grants", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
